// File: rtl/pattern_resp_misr.sv
// Compacts a run of 12-bit pattern responses into a 16-bit MISR signature.
// At the end of the run the signature is compared against a golden value.
module pattern_resp_misr #(
  parameter int          NUM_SAMPLES = 16,
  parameter logic [15:0] SEED        = 16'h0000
) (
  input  logic        blif_clk_net,
  input  logic        blif_reset_net,
  input  logic        start,
  input  logic        abort,
  input  logic        resp_valid,
  input  logic [11:0] resp,
  input  logic [15:0] expected_sig,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] signature,
  output logic [7:0]  sample_count
);

  localparam logic [7:0] LAST_COUNT = 8'(NUM_SAMPLES);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state_q, state_d;
  logic [15:0] sig_q, sig_d, sig_next;
  logic [7:0]  cnt_q, cnt_d, cnt_inc;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;

  // CRC-16/CCITT style shift with the response word folded into the low bits.
  always_comb begin
    sig_next = {sig_q[14:0], 1'b0} ^ (sig_q[15] ? 16'h1021 : 16'h0000) ^ {4'b0000, resp};
    cnt_inc  = cnt_q + 8'd1;
  end

  always_comb begin
    state_d = state_q;
    sig_d   = sig_q;
    cnt_d   = cnt_q;
    pass_d  = pass_q;
    done_d  = 1'b0;
    if (abort) begin
      state_d = IDLE;
      pass_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_d = RUN;
            sig_d   = SEED;
            cnt_d   = 8'd0;
            pass_d  = 1'b0;
          end
        end
        RUN: begin
          if (resp_valid) begin
            sig_d = sig_next;
            cnt_d = cnt_inc;
            if (cnt_inc == LAST_COUNT) begin
              state_d = DONE;
              done_d  = 1'b1;
              pass_d  = (sig_next == expected_sig);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d == RUN);
  end

  always_ff @(posedge blif_clk_net or negedge blif_reset_net) begin
    if (!blif_reset_net) begin
      state_q <= IDLE;
      sig_q   <= SEED;
      cnt_q   <= 8'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign signature    = sig_q;
  assign sample_count = cnt_q;

endmodule

// File: tb/tb_pattern_resp_misr.sv
// Directed and randomized bench for pattern_resp_misr; four instances with
// different run lengths and seeds share one stimulus bus.
module tb_pattern_resp_misr;

  localparam int          NR     = 5;
  localparam logic [15:0] SEED_R = 16'hACE1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0, abort = 1'b0, resp_valid = 1'b0;
  logic [11:0] resp = 12'h000;
  logic [15:0] expected_sig = 16'h0000;

  logic        busy1, done1, pass1, busy2, done2, pass2;
  logic        busy3, done3, pass3, busyr, doner, passr;
  logic [15:0] sig1, sig2, sig3, sigr;
  logic [7:0]  cnt1, cnt2, cnt3, cntr;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  pattern_resp_misr #(.NUM_SAMPLES(1), .SEED(16'h0000)) u1 (
    .blif_clk_net(clk), .blif_reset_net(rst_n), .start(start), .abort(abort),
    .resp_valid(resp_valid), .resp(resp), .expected_sig(expected_sig),
    .busy(busy1), .done(done1), .pass(pass1), .signature(sig1), .sample_count(cnt1));

  pattern_resp_misr #(.NUM_SAMPLES(2), .SEED(16'h0000)) u2 (
    .blif_clk_net(clk), .blif_reset_net(rst_n), .start(start), .abort(abort),
    .resp_valid(resp_valid), .resp(resp), .expected_sig(expected_sig),
    .busy(busy2), .done(done2), .pass(pass2), .signature(sig2), .sample_count(cnt2));

  pattern_resp_misr #(.NUM_SAMPLES(1), .SEED(16'hFFFF)) u3 (
    .blif_clk_net(clk), .blif_reset_net(rst_n), .start(start), .abort(abort),
    .resp_valid(resp_valid), .resp(resp), .expected_sig(expected_sig),
    .busy(busy3), .done(done3), .pass(pass3), .signature(sig3), .sample_count(cnt3));

  pattern_resp_misr #(.NUM_SAMPLES(NR), .SEED(SEED_R)) ur (
    .blif_clk_net(clk), .blif_reset_net(rst_n), .start(start), .abort(abort),
    .resp_valid(resp_valid), .resp(resp), .expected_sig(expected_sig),
    .busy(busyr), .done(doner), .pass(passr), .signature(sigr), .sample_count(cntr));

  // Reference signature step: double the value, fold the overflow back
  // through the polynomial, then mix in the response word.
  function automatic logic [15:0] model_step(input logic [15:0] s, input logic [11:0] w);
    int v;
    v = int'(s) * 2;
    if (v >= 65536) v = (v - 65536) ^ 32'h1021;
    return 16'(v ^ int'(w));
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] sig_m, nxt;
  logic [11:0] w;
  int          cnt_m;

  initial begin
    // Asynchronous reset, checked before any clock edge.
    #1 rst_n = 1'b0;
    #2;
    check("rst_async_sig1", sig1, 16'h0000);
    check("rst_async_sig3", sig3, 16'hFFFF);
    check("rst_async_cnt1", 16'(cnt1), 16'h0000);
    check("rst_async_busy1", 16'(busy1), 16'h0000);
    tick();
    tick();
    rst_n = 1'b1;

    // V1: idle after reset with no start.
    repeat (3) tick();
    check("v1_busy", 16'(busy1), 16'h0000);
    check("v1_done", 16'(done1), 16'h0000);
    check("v1_pass", 16'(pass1), 16'h0000);
    check("v1_sig", sig1, 16'h0000);
    check("v1_cnt", 16'(cnt1), 16'h0000);
    check("v1_busyr", 16'(busyr), 16'h0000);

    // V2: single-word run; valid in the start cycle is ignored.
    start = 1'b1; resp_valid = 1'b1; resp = 12'hFFF;
    tick();
    start = 1'b0;
    check("v2_busy", 16'(busy1), 16'h0001);
    check("v2_start_sig", sig1, 16'h0000);
    check("v2_start_cnt", 16'(cnt1), 16'h0000);
    check("v2_start_sig3", sig3, 16'hFFFF);
    resp = 12'hABC; expected_sig = 16'h0ABC;
    tick();
    resp_valid = 1'b0;
    check("v2_sig", sig1, 16'h0ABC);
    check("v2_done", 16'(done1), 16'h0001);
    check("v2_pass", 16'(pass1), 16'h0001);
    check("v2_cnt", 16'(cnt1), 16'h0001);
    check("v2_busy_off", 16'(busy1), 16'h0000);
    tick();
    check("v2_done_pulse", 16'(done1), 16'h0000);
    check("v2_pass_hold", 16'(pass1), 16'h0001);

    // V3: two-word run with gaps, wrong golden signature.
    tick();
    check("v3_gap_sig", sig2, 16'h0ABC);
    check("v3_gap_cnt", 16'(cnt2), 16'h0001);
    check("v3_gap_busy", 16'(busy2), 16'h0001);
    resp = 12'h000; resp_valid = 1'b1; expected_sig = 16'h1579;
    tick();
    resp_valid = 1'b0;
    check("v3_sig", sig2, 16'h1578);
    check("v3_cnt", 16'(cnt2), 16'h0002);
    check("v3_done", 16'(done2), 16'h0001);
    check("v3_pass", 16'(pass2), 16'h0000);
    check("v3_done_frozen", sig1, 16'h0ABC);

    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_pass_clr", 16'(pass1), 16'h0000);
    check("abort_sig_keep", sig1, 16'h0ABC);
    check("abort_busyr", 16'(busyr), 16'h0000);

    // V4: all-ones seed.
    start = 1'b1;
    tick();
    start = 1'b0;
    resp = 12'h000; resp_valid = 1'b1;
    tick();
    resp_valid = 1'b0;
    check("v4_sig", sig3, 16'hEFDF);
    check("v4_done", 16'(done3), 16'h0001);
    abort = 1'b1;
    tick();
    abort = 1'b0;

    // V5: three words (one with an ignored start), then start+abort together.
    start = 1'b1;
    tick();
    start = 1'b0;
    sig_m = SEED_R; cnt_m = 0;
    for (int i = 0; i < 3; i++) begin
      w = 12'($urandom);
      resp = w; resp_valid = 1'b1; start = (i == 1);
      tick();
      sig_m = model_step(sig_m, w); cnt_m++;
      check("v5_sig", sigr, sig_m);
      check("v5_cnt", 16'(cntr), 16'(cnt_m));
    end
    start = 1'b1; abort = 1'b1; resp_valid = 1'b1; resp = 12'h5A5;
    tick();
    start = 1'b0; abort = 1'b0; resp_valid = 1'b0;
    check("v5_busy", 16'(busyr), 16'h0000);
    check("v5_cnt_keep", 16'(cntr), 16'h0003);
    check("v5_sig_keep", sigr, sig_m);
    check("v5_no_done", 16'(doner), 16'h0000);
    tick();
    check("v5_idle_done", 16'(doner), 16'h0000);
    check("v5_idle_busy", 16'(busyr), 16'h0000);

    // V6: reset mid-run, then a restart from DONE.
    start = 1'b1;
    tick();
    start = 1'b0;
    resp = 12'h123; resp_valid = 1'b1;
    repeat (2) tick();
    resp_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    check("v6_rst_sig", sigr, SEED_R);
    check("v6_rst_cnt", 16'(cntr), 16'h0000);
    check("v6_rst_busy", 16'(busyr), 16'h0000);
    check("v6_rst_done", 16'(doner), 16'h0000);
    check("v6_rst_pass", 16'(passr), 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("v6_post_done", 16'(doner), 16'h0000);
    check("v6_post_busy", 16'(busyr), 16'h0000);
    start = 1'b1;
    tick();
    start = 1'b0;
    resp = 12'hABC; resp_valid = 1'b1; expected_sig = 16'h0ABC;
    tick();
    resp_valid = 1'b0;
    check("v6_run_pass", 16'(pass1), 16'h0001);
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("v6_restart_sig", sig1, 16'h0000);
    check("v6_restart_pass", 16'(pass1), 16'h0000);
    check("v6_restart_cnt", 16'(cnt1), 16'h0000);
    check("v6_restart_busy", 16'(busy1), 16'h0001);
    abort = 1'b1;
    tick();
    abort = 1'b0;

    // Randomized runs on the NR-word instance against the reference model.
    for (int run = 0; run < 25; run++) begin
      bit finished;
      start = 1'b1; resp_valid = 1'b0;
      tick();
      start = 1'b0;
      sig_m = SEED_R; cnt_m = 0; finished = 1'b0;
      check("rnd_start_sig", sigr, sig_m);
      check("rnd_start_busy", 16'(busyr), 16'h0001);
      for (int cyc = 0; cyc < 100 && !finished; cyc++) begin
        bit v, ab, good, completing;
        v = 1'($urandom_range(0, 1));
        ab = ($urandom_range(0, 31) == 0);
        good = 1'($urandom_range(0, 1));
        w = 12'($urandom);
        nxt = model_step(sig_m, w);
        completing = v && !ab && (cnt_m + 1 == NR);
        resp = w; resp_valid = v; abort = ab;
        start = ($urandom_range(0, 3) == 0);
        expected_sig = completing ? (good ? nxt : nxt ^ 16'h8000) : 16'($urandom);
        tick();
        start = 1'b0; abort = 1'b0; resp_valid = 1'b0;
        if (!ab && v) begin
          sig_m = nxt;
          cnt_m++;
        end
        check("rnd_sig", sigr, sig_m);
        check("rnd_cnt", 16'(cntr), 16'(cnt_m));
        check("rnd_done", 16'(doner), 16'(completing));
        check("rnd_busy", 16'(busyr), 16'(!completing && !ab));
        if (completing) check("rnd_pass", 16'(passr), 16'(good));
        if (ab) check("rnd_abort_pass", 16'(passr), 16'h0000);
        if (ab || completing) finished = 1'b1;
      end
      if (!finished) begin
        tests_run++;
        tests_failed++;
        $error("[TB] FAIL rnd_timeout: observed no completion expected done within 100 cycles");
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pattern_resp_misr.md
PATTERN_RESP_MISR -- requirements
Module: pattern_resp_misr

Interface
REQ-001 Parameter NUM_SAMPLES, default 16: number of accepted response words per signature run; legal range 1..255.
REQ-002 Parameter SEED, default 16'h0000: signature register value loaded at each run start.
REQ-003 blif_clk_net  input  1  single clock; every flop rises on its posedge.
REQ-004 blif_reset_net  input  1  reset; asynchronous, active-low.
REQ-005 start  input  1  run request; sampled only in IDLE or DONE.
REQ-006 abort  input  1  synchronous cancel of the current run.
REQ-007 resp_valid  input  1  the response word is valid this cycle.
REQ-008 resp  input  12  response word from the upstream 12-output pattern stage; bit order {N1371_0, N1508_0, N1372_1, N1508_1, N6147_2, N1507_6, N1508_6, G42_7, n_572_7, n_573_7, n_569_7, n_452_7}, MSB first.
REQ-009 expected_sig  input  16  golden signature; sampled on the completing cycle.
REQ-010 busy  output  1  high while in RUN.
REQ-011 done  output  1  one-cycle pulse on entry to DONE.
REQ-012 pass  output  1  comparison result; valid from the done pulse until the next run start.
REQ-013 signature  output  16  current MISR contents.
REQ-014 sample_count  output  8  number of words accepted in the current run.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-016 The FSM SHALL make the following transitions:
- IDLE -> RUN on start
- DONE -> RUN on start
- RUN -> DONE on the cycle that accepts sample NUM_SAMPLES
- any state -> IDLE on abort
REQ-017 Abort SHALL take priority over start and over resp_valid in the same cycle.
REQ-018 The run-start cycle SHALL load signature=SEED, sample_count=0 and pass=0.
REQ-019 resp_valid in that run-start cycle SHALL be ignored.
REQ-020 A word SHALL be accepted only when state=RUN, resp_valid=1 and abort=0.
REQ-021 No back-pressure is provided: every qualifying word SHALL be consumed in the same cycle.
REQ-022 On accept, the MISR SHALL update as sig_next = (sig<<1, 16 bits) XOR (sig[15] ? 16'h1021 : 0) XOR {4'b0, resp}.
REQ-023 On accept, sample_count SHALL increment by 1.
REQ-024 The accepting cycle that brings sample_count to NUM_SAMPLES SHALL move the FSM to DONE.
REQ-025 That cycle SHALL register pass = (sig_next == expected_sig).
REQ-026 done SHALL be high exactly in the first DONE cycle; latency from the final accepted word to done is 1 clock.
REQ-027 signature and sample_count SHALL hold in IDLE and DONE, and in RUN while resp_valid=0.
REQ-028 start while in RUN SHALL be ignored; the run continues unaffected.
REQ-029 In DONE, resp_valid SHALL be ignored and the signature SHALL be frozen.
REQ-030 Abort SHALL leave signature and sample_count unchanged and SHALL clear pass and busy.
REQ-031 sample_count SHALL never exceed NUM_SAMPLES and SHALL never wrap.
REQ-032 All outputs SHALL be registered; there are no combinational input-to-output paths.

Reset
REQ-033 blif_reset_net low SHALL immediately force the following, regardless of the clock:
- state=IDLE
- signature=SEED
- sample_count=0
- busy=0, done=0, pass=0
REQ-034 Reset asserted mid-run SHALL discard the partial signature; no done pulse follows.
REQ-035 After reset deasserts, the block SHALL remain idle until the first clock edge with start=1.

Verification
REQ-036 The bench SHALL cover these scenarios:
- V1: reset low then high, no start -> busy=0, done=0, pass=0, signature=0x0000, sample_count=0.
- V2: NUM_SAMPLES=1, SEED=0, start, then resp=0xABC with valid, expected_sig=0x0ABC -> signature=0x0ABC, done pulses 1 cycle, pass=1.
- V3: NUM_SAMPLES=2, SEED=0, words 0xABC then 0x000, with idle valid-low gaps between them -> signature=0x1578, sample_count=2; expected_sig=0x1579 gives pass=0.
- V4: SEED=0xFFFF, NUM_SAMPLES=1, resp=0x000 -> signature=0xEFDF.
- V5: in RUN after 3 words, assert start and abort together -> IDLE, busy=0, sample_count=3, no done pulse.
- V6: reset pulsed low mid-run, then a start from DONE -> all outputs return to reset values; the new run restarts from SEED with pass cleared.
